// File: rtl/tdm_mux8_tx_pkg.sv
// tdm_pkg: shared constants, state type and divider width helper for the TDM transmitter
package tdm_pkg;
  localparam int NCH = 8;
  localparam int SEL_W = 3;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic int div_w(input int d);
    return (d > 2) ? $clog2(d) : 1;
  endfunction
endpackage

// File: rtl/tdm_mux8_tx_if.sv
// tdm_mux8_if: frame request inputs and serial slot outputs of the TDM transmitter
interface tdm_mux8_if;
  import tdm_pkg::*;
  logic [NCH-1:0] din;
  logic start;
  logic en_n;
  logic [SEL_W-1:0] sel;
  logic dout;
  logic oe_n;
  logic busy;
  logic done;
  modport master(output din, start, en_n, input sel, dout, oe_n, busy, done);
  modport slave(input din, start, en_n, output sel, dout, oe_n, busy, done);
endinterface

// File: rtl/tdm_mux8_tx_slot_timer.sv
// tdm_slot_timer: counts 0..DIV-1 while running and flags the last cycle of each slot
module tdm_slot_timer import tdm_pkg::*; #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic slot_end
);
  localparam int W = div_w(DIV);
  logic [W-1:0] cnt;
  assign slot_end = run && cnt == W'(DIV - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (clear || slot_end) ? '0 : run ? cnt + W'(1) : cnt;
endmodule

// File: rtl/tdm_mux8_tx.sv
// tdm_mux8_tx: snapshots 8 bits on start and serializes them one per DIV-cycle slot with sel/oe_n
module tdm_mux8_tx import tdm_pkg::*; #(
  parameter int DIV = 4,
  parameter int LOOP = 0
) (
  input logic clk,
  input logic rst,
  tdm_mux8_if.slave bus
);
  state_t state, state_d;
  logic [NCH-1:0] shadow, shadow_d;
  logic [SEL_W-1:0] sel_d;
  logic dout_d, oe_n_d, busy_d, done_d, slot_end, last;
  tdm_slot_timer #(.DIV(DIV)) u_timer (
    .clk,
    .rst,
    .clear(state == IDLE),
    .run(state == RUN),
    .slot_end
  );
  assign last = slot_end && bus.sel == SEL_W'(NCH - 1);
  always_comb begin
    state_d = state;
    shadow_d = shadow;
    sel_d = bus.sel;
    dout_d = bus.dout;
    oe_n_d = bus.oe_n;
    busy_d = bus.busy;
    done_d = 1'b0;
    if (state == IDLE) begin
      if (bus.start && !bus.en_n) begin
        state_d = RUN;
        shadow_d = bus.din;
        sel_d = '0;
        dout_d = bus.din[0];
        oe_n_d = 1'b0;
        busy_d = 1'b1;
      end
    end else if (last) begin
      // frame completion outranks a simultaneous abort, so done still pulses
      done_d = 1'b1;
      sel_d = '0;
      if (LOOP != 0 && !bus.en_n) begin
        shadow_d = bus.din;
        dout_d = bus.din[0];
      end else begin
        state_d = IDLE;
        dout_d = 1'b0;
        oe_n_d = 1'b1;
        busy_d = 1'b0;
      end
    end else if (bus.en_n) begin
      state_d = IDLE;
      sel_d = '0;
      dout_d = 1'b0;
      oe_n_d = 1'b1;
      busy_d = 1'b0;
    end else if (slot_end) begin
      sel_d = bus.sel + SEL_W'(1);
      dout_d = shadow[bus.sel + SEL_W'(1)];
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      shadow <= '0;
      bus.sel <= '0;
      bus.dout <= 1'b0;
      bus.oe_n <= 1'b1;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state <= state_d;
      shadow <= shadow_d;
      bus.sel <= sel_d;
      bus.dout <= dout_d;
      bus.oe_n <= oe_n_d;
      bus.busy <= busy_d;
      bus.done <= done_d;
    end
endmodule

// File: tb/tb_tdm_mux8_tx.sv
// tb_tdm_mux8_tx: frame-timeline model plus directed checks for DIV=4/LOOP=0 and DIV=1/LOOP=1 instances
module tb_tdm_mux8_tx;
  localparam int DA = 4, LA = 0, DB = 1, LB = 1;
  logic clk, rst;
  tdm_mux8_if ia ();
  tdm_mux8_if ib ();
  logic [7:0] din_v[2];
  logic start_v[2], en_v[2];
  logic [2:0] o_sel[2];
  logic o_dout[2], o_oe_n[2], o_busy[2], o_done[2];
  int tests = 0, fails = 0;
  bit run_chk = 0;
  bit act[2];
  bit de[2];
  int pos[2];
  logic [7:0] snap[2];

  assign ia.din = din_v[0];
  assign ia.start = start_v[0];
  assign ia.en_n = en_v[0];
  assign ib.din = din_v[1];
  assign ib.start = start_v[1];
  assign ib.en_n = en_v[1];
  assign o_sel[0] = ia.sel;
  assign o_dout[0] = ia.dout;
  assign o_oe_n[0] = ia.oe_n;
  assign o_busy[0] = ia.busy;
  assign o_done[0] = ia.done;
  assign o_sel[1] = ib.sel;
  assign o_dout[1] = ib.dout;
  assign o_oe_n[1] = ib.oe_n;
  assign o_busy[1] = ib.busy;
  assign o_done[1] = ib.done;

  tdm_mux8_tx #(.DIV(DA), .LOOP(LA)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  tdm_mux8_tx #(.DIV(DB), .LOOP(LB)) dut_b (.clk(clk), .rst(rst), .bus(ib));

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic int div_of(input int n);
    return n == 0 ? DA : DB;
  endfunction
  function automatic bit loop_of(input int n);
    return n == 0 ? (LA != 0) : (LB != 0);
  endfunction

  // receiver: 1:8 active-low-enable demux built from two 1:4 halves chosen by sel[2]
  function automatic logic [3:0] dmx4(input logic [1:0] s, input logic d, input logic en);
    return en ? ({3'b000, d} << s) : 4'b0000;
  endfunction
  function automatic logic [7:0] demux8(input logic [2:0] s, input logic d, input logic oe_n);
    return {dmx4(s[1:0], d, !oe_n && s[2]), dmx4(s[1:0], d, !oe_n && !s[2])};
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // model: a frame is a run of 8*DIV cycles; position in it gives slot and bit directly
  always @(posedge clk or posedge rst) begin
    for (int n = 0; n < 2; n++) begin
      if (rst) begin
        act[n] = 0;
        pos[n] = 0;
        de[n] = 0;
      end else begin
        de[n] = 0;
        if (act[n]) begin
          pos[n]++;
          if (pos[n] == 8 * div_of(n)) begin
            de[n] = 1;
            if (loop_of(n) && !en_v[n]) begin
              pos[n] = 0;
              snap[n] = din_v[n];
            end else act[n] = 0;
          end else if (en_v[n]) act[n] = 0;
        end else if (start_v[n] && !en_v[n]) begin
          act[n] = 1;
          pos[n] = 0;
          snap[n] = din_v[n];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      for (int n = 0; n < 2; n++) begin
        chk(n ? "b_sel" : "a_sel", o_sel[n], act[n] ? 32'(pos[n] / div_of(n)) : 0);
        chk(n ? "b_dout" : "a_dout", o_dout[n], act[n] ? snap[n][pos[n] / div_of(n)] : 1'b0);
        chk(n ? "b_oe_n" : "a_oe_n", o_oe_n[n], !act[n]);
        chk(n ? "b_busy" : "a_busy", o_busy[n], act[n]);
        chk(n ? "b_done" : "a_done", o_done[n], de[n]);
      end
    end
  end

  task automatic frame_a(input logic [7:0] dv, input bit toggle, input int abort_at);
    logic [7:0] v;
    int low, dones, done_at, s;
    v = 0;
    low = 0;
    dones = 0;
    done_at = 0;
    din_v[0] = dv;
    start_v[0] = 1;
    for (int i = 1; i <= 40; i++) begin
      tick;
      if (i == 1) start_v[0] = 0;
      if (toggle && i == 10) din_v[0] = 8'hFF;
      if (toggle && i == 15) start_v[0] = 1;
      if (toggle && i == 16) start_v[0] = 0;
      s = (i <= 32) ? (i - 1) / 4 : 0;
      if (!o_oe_n[0]) low++;
      if (i <= 32 && !o_oe_n[0]) v[s] = o_dout[0];
      if (o_done[0]) begin
        dones++;
        done_at = i;
      end
      chk("e2e_demux", demux8(o_sel[0], o_dout[0], o_oe_n[0]),
          (i <= 32 && (abort_at == 0 || i <= abort_at)) ? ({7'b0, dv[s]} << s) : 8'h00);
      if (abort_at != 0 && i == abort_at + 1) begin
        chk("abort_oe_n", o_oe_n[0], 1);
        chk("abort_busy", o_busy[0], 0);
        chk("abort_sel", o_sel[0], 0);
        chk("abort_dout", o_dout[0], 0);
      end
      if (abort_at != 0 && i == abort_at) en_v[0] = 1;
    end
    if (abort_at != 0) begin
      chk("abort_low_cycles", low, abort_at);
      chk("abort_no_done", dones, 0);
      en_v[0] = 0;
    end else begin
      chk("frame_low_cycles", low, 32);
      chk("frame_bits", v, dv);
      chk("frame_done_count", dones, 1);
      chk("frame_done_cycle", done_at, 33);
    end
  endtask

  initial begin
    int k;
    rst = 1;
    for (int n = 0; n < 2; n++) begin
      din_v[n] = 0;
      start_v[n] = 0;
      en_v[n] = 1;
    end
    tick;
    tick;
    tick;
    rst = 0;
    run_chk = 1;
    chk("rst_sel", o_sel[0], 0);
    chk("rst_dout", o_dout[0], 0);
    chk("rst_oe_n", o_oe_n[0], 1);
    chk("rst_busy", o_busy[0], 0);
    chk("rst_done", o_done[0], 0);
    start_v[0] = 1;
    tick;
    tick;
    chk("en_n_blocks_busy", o_busy[0], 0);
    chk("en_n_blocks_oe_n", o_oe_n[0], 1);
    start_v[0] = 0;
    en_v[0] = 0;
    tick;
    tick;
    frame_a(8'hA6, 0, 0);
    frame_a(8'hA6, 1, 0);
    frame_a(8'hA6, 0, 14);
    frame_a(8'hA6, 0, 0);
    frame_a(8'h5B, 0, 0);
    // start held in IDLE relaunches on the cycle after done
    start_v[0] = 1;
    for (k = 0; k < 60 && !o_done[0]; k++) tick;
    chk("held_done_seen", o_done[0], 1);
    tick;
    chk("held_restart_busy", o_busy[0], 1);
    chk("held_restart_oe_n", o_oe_n[0], 0);
    chk("held_restart_sel", o_sel[0], 0);
    start_v[0] = 0;
    for (k = 0; k < 60 && !o_done[0]; k++) tick;
    chk("held_second_done", o_done[0], 1);
    tick;
    // asynchronous reset in the middle of slot 1
    start_v[0] = 1;
    tick;
    start_v[0] = 0;
    for (int i = 0; i < 5; i++) tick;
    #2 rst = 1;
    #1;
    chk("async_rst_sel", o_sel[0], 0);
    chk("async_rst_dout", o_dout[0], 0);
    chk("async_rst_oe_n", o_oe_n[0], 1);
    chk("async_rst_busy", o_busy[0], 0);
    chk("async_rst_done", o_done[0], 0);
    tick;
    tick;
    tick;
    chk("rst_held_busy", o_busy[0], 0);
    chk("rst_held_oe_n", o_oe_n[0], 1);
    rst = 0;
    tick;
    tick;
    chk("post_rst_no_done", o_done[0], 0);
    // free-running DIV=1 frames
    en_v[1] = 0;
    din_v[1] = 8'h81;
    start_v[1] = 1;
    tick;
    start_v[1] = 0;
    for (int i = 1; i <= 24; i++) begin
      chk("loop_sel", o_sel[1], (i - 1) % 8);
      chk("loop_dout", o_dout[1], ((i - 1) % 8 == 0 || (i - 1) % 8 == 7) ? 1 : 0);
      chk("loop_done", o_done[1], (i > 1 && (i - 1) % 8 == 0) ? 1 : 0);
      chk("loop_oe_n", o_oe_n[1], 0);
      tick;
    end
    en_v[1] = 1;
    tick;
    tick;
    chk("loop_stopped_busy", o_busy[1], 0);
    chk("loop_stopped_oe_n", o_oe_n[1], 1);
    tick;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tdm_mux8_tx.md
Name: tdm_mux8_tx

Overview:
- Sequential 8:1 time-division multiplexer and serializer. It is the transmit end feeding an 8-output active-low-enable demux (1:8 built from two 1:4).
- On a start request it snapshots 8 parallel input bits. It then presents them one per slot on dout, with the matching 3-bit channel select on sel and an active-low enable on oe_n.
- The far-end demux routes each bit back to its output line.
- Sits between switch/sensor inputs and the demux-based display/decoder path.

Parameters:
- DIV, 4: clock cycles per channel slot; legal range 1..255.
- LOOP, 0: 0 = one frame per start; 1 = free-running frames while en_n is low.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  8  parallel channel data; din[k] is sent in slot k.
- start  input  1  frame request; level-sampled in IDLE.
- en_n  input  1  active-low block enable; high aborts or blocks frames.
- sel  output  3  current channel index; sel[2] selects the upper/lower 1:4 half at the receiver.
- dout  output  1  serial data bit for the current slot.
- oe_n  output  1  active-low receiver enable; low only while a slot is valid.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse at normal frame completion.

Behaviour:
- All outputs registered.
- Reset values: sel=0, dout=0, oe_n=1, busy=0, done=0. Internal shadow=0, slot counter=0, divider=0, state=IDLE.
- States: IDLE, RUN.
- IDLE -> RUN: at edge t, if start=1 and en_n=0.
  - At t+1: shadow=din (sampled at t), sel=0, dout=din[0], oe_n=0, busy=1.
- RUN, slot timing:
  - The divider counts 0..DIV-1, so each slot lasts exactly DIV cycles.
  - Slot k occupies cycles t+1+k*DIV through t+(k+1)*DIV.
  - When the divider wraps with sel<7: sel increments, dout=shadow[sel+1], divider=0.
- RUN, end of slot 7 (cycle t+1+8*DIV):
  - LOOP=0, or en_n=1: state=IDLE, oe_n=1, busy=0, sel=0, dout=0, done=1 for this cycle only.
  - LOOP=1 and en_n=0: done=1 for one cycle. In the same cycle a new snapshot shadow=din is taken, sel=0, dout=din[0], oe_n=0 and busy stays 1. There is no idle gap between frames.
- dout is always taken from shadow; din changes during a frame have no effect.
- start while busy=1 is ignored; there is no queuing.
- start=1 held in IDLE with LOOP=0 starts a new frame on the cycle after done.
- en_n rises during RUN (abort):
  - Next edge: state=IDLE, oe_n=1, busy=0, sel=0, dout=0.
  - done is not pulsed. The partial frame is discarded.
- en_n=1 in IDLE: start is ignored.
- Asynchronous rst at any time forces reset values immediately, including mid-slot. No done pulse.
- DIV=1: one slot per cycle. sel steps 0..7 on consecutive cycles and the frame spans 8 cycles.
- Receiver contract: with oe_n=1 the receiver sees enable inactive, so all outputs are low. Each receiver output k equals din[k] only during slot k. Latching is the receiver's job.

Decomposition:
- Shared package tdm_pkg holds:
  - constants NCH=8, SEL_W=3;
  - the state type {IDLE, RUN};
  - DIV_W = max(1, clog2(DIV)) width function.
- One sub-module, tdm_slot_timer:
  - takes clk, rst, clear and run;
  - counts 0..DIV-1 and emits a slot_end pulse on wrap.
- The top module holds the FSM, shadow register, sel counter and output registers.

Test Plan:
- Reset/idle: assert rst mid-simulation for 3 cycles -> sel=0, dout=0, oe_n=1, busy=0, done=0 immediately and held; start while en_n=1 -> no change.
- Single frame, DIV=4, LOOP=0: din=8'b1010_0110, start pulse at cycle 10 -> oe_n low cycles 11..42; sel=k during cycles 11+4k..14+4k; dout sequence 0,1,1,0,0,1,0,1; done=1 at cycle 43 only; busy low from 43.
- Snapshot isolation: same frame, din toggled to 8'hFF at cycle 20 and start re-pulsed at 25 -> dout still 0,1,1,0,0,1,0,1; second start ignored; exactly one done.
- Abort: en_n raised at cycle 24 of the frame above -> at 25 oe_n=1, busy=0, sel=0, dout=0; no done pulse; new start at 30 gives a fresh frame from slot 0.
- DIV=1, LOOP=1, en_n=0, din=8'h81: sel 0..7 on consecutive cycles repeating; dout 1,0,0,0,0,0,0,1 per frame; done pulses every 8th cycle coincident with sel returning to 0; oe_n never rises.
- End-to-end: drive sel/dout/oe_n into the 1:8 active-low-enable demux -> its output k is high exactly during slot k when din[k]=1; all outputs low while oe_n=1.
